// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the pulse width meter: default parameter values,
// the measurement FSM state encoding and the default-width queue entry layout.
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int CNT_W_DEF      = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HIGH = 1'b1
    } state_t;

    // Queue entry as stored in the FIFO: saturation flag above the width.
    typedef struct packed {
        logic                 sat;
        logic [CNT_W_DEF-1:0] width;
    } entry_t;

endpackage

// File: rtl/meas_fifo.sv
// -----------------------------------------------------------------------------
// meas_fifo
// Synchronous circular-buffer FIFO holding pulse measurements.
//   clock, reset   : rising-edge clock, asynchronous active-low reset
//   flush          : synchronous empty (pointers and occupancy to zero)
//   push, wdata    : write request and data; accepted when not full, or when
//                    full and a pop happens in the same cycle
//   pop            : read request; ignored when empty
//   rdata          : head entry, forced to zero while empty
//   full, empty    : occupancy status
//   level          : current occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module meas_fifo
    import pwm_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEF + 1,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign push_ok = push & (~full | pop_ok);
    assign level   = count;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= AW'(wr_ptr + 1'b1);
            if (pop_ok)  rd_ptr <= AW'(rd_ptr + 1'b1);
            count <= (AW+1)'(count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok});
        end
    end

    // Storage is data only; the pointers decide what is valid.
    always_ff @(posedge clock) begin
        if (push_ok && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pulse_width_meter.sv
// -----------------------------------------------------------------------------
// pulse_width_meter
// Measures the width (in clock cycles) of each high pulse on the filtered
// signal, queues the measurements and hands them out over valid/ready.
//   clock       : system clock, rising edge
//   reset       : asynchronous active-low reset
//   sig_in      : filtered input signal, synchronous to clock
//   clear       : synchronous flush of queue, sticky flag and measurement
//   meas_data   : width of the oldest queued pulse
//   meas_sat    : oldest queued pulse reached counter saturation
//   meas_valid  : queue non-empty
//   meas_ready  : consumer takes the head entry when meas_valid is high
//   drop_flag   : sticky, a completed pulse was lost to a full queue
//   fill_level  : current queue occupancy
// -----------------------------------------------------------------------------
module pulse_width_meter
    import pwm_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int MIN_WIDTH  = 1,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             clear,
    output logic [CNT_W-1:0] meas_data,
    output logic             meas_sat,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             drop_flag,
    output logic [LVL_W-1:0] fill_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_WIDTH);

    state_t           state;
    logic             sig_d;
    logic [CNT_W-1:0] counter;
    logic             sat;
    logic             rise;
    logic             fall;
    logic             push_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W:0]   head;

    assign rise = sig_in & ~sig_d;
    assign fall = ~sig_in & sig_d;

    // Pulses below the minimum width end without ever reaching the queue.
    assign push_req = (state == HIGH) && fall && (counter >= MIN_W) && !clear;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // sig_d starts high so a level already high at release is not a rise.
            sig_d     <= 1'b1;
            state     <= IDLE;
            counter   <= '0;
            sat       <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            sig_d <= sig_in;
            if (clear) begin
                state     <= IDLE;
                counter   <= '0;
                sat       <= 1'b0;
                drop_flag <= 1'b0;
            end else begin
                // A full queue with no pop this cycle loses the new entry.
                if (push_req && fifo_full && !meas_ready) drop_flag <= 1'b1;
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state   <= HIGH;
                            counter <= CNT_W'(1);
                            sat     <= 1'b0;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state <= IDLE;
                        end else if (counter != CNT_MAX) begin
                            counter <= CNT_W'(counter + 1'b1);
                            if (counter == CNT_W'(CNT_MAX - 1'b1)) sat <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    meas_fifo #(
        .WIDTH (CNT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (clear),
        .push  (push_req),
        .wdata ({sat, counter}),
        .pop   (meas_ready),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fill_level)
    );

    assign meas_valid = ~fifo_empty;
    assign meas_sat   = head[CNT_W];
    assign meas_data  = head[CNT_W-1:0];

endmodule

// File: tb/tb_pulse_width_meter.sv
module tb_pulse_width_meter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sig_in = 1'b0;
    logic       clear = 1'b0;
    logic       meas_ready = 1'b0;

    logic [7:0] meas_data;
    logic       meas_sat;
    logic       meas_valid;
    logic       drop_flag;
    logic [2:0] fill_level;

    logic [7:0] m3_data;
    logic       m3_sat;
    logic       m3_valid;
    logic       m3_drop;
    logic [2:0] m3_fill;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pulse_width_meter #(.CNT_W(8), .FIFO_DEPTH(4), .MIN_WIDTH(1)) u_dut (
        .clock(clock), .reset(reset), .sig_in(sig_in), .clear(clear),
        .meas_data(meas_data), .meas_sat(meas_sat), .meas_valid(meas_valid),
        .meas_ready(meas_ready), .drop_flag(drop_flag), .fill_level(fill_level)
    );

    pulse_width_meter #(.CNT_W(8), .FIFO_DEPTH(4), .MIN_WIDTH(3)) u_dut3 (
        .clock(clock), .reset(reset), .sig_in(sig_in), .clear(clear),
        .meas_data(m3_data), .meas_sat(m3_sat), .meas_valid(m3_valid),
        .meas_ready(meas_ready), .drop_flag(m3_drop), .fill_level(m3_fill)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives a pulse sampled high at w edges; leaves sig_in low, un-ticked.
    task automatic pulse(input int w);
        sig_in = 1'b1;
        repeat (w) tick();
        sig_in = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        tick();
        tick();
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", meas_valid); end
        checks++; if (meas_data !== 8'd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", meas_data); end
        checks++; if (meas_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got=%0b exp=0", meas_sat); end
        checks++; if (drop_flag !== 1'b0) begin errors++; $display("FAIL reset_drop got=%0b exp=0", drop_flag); end
        checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_widths();
        int widths [3] = '{1, 3, 17};
        meas_ready = 1'b1;
        foreach (widths[i]) begin
            pulse(widths[i]);
            checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL width_early_valid w=%0d got=%0b exp=0", widths[i], meas_valid); end
            tick();
            checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL width_valid w=%0d got=%0b exp=1", widths[i], meas_valid); end
            checks++; if (meas_data !== 8'(widths[i])) begin errors++; $display("FAIL width_data got=%0d exp=%0d", meas_data, widths[i]); end
            checks++; if (meas_sat !== 1'b0) begin errors++; $display("FAIL width_sat w=%0d got=%0b exp=0", widths[i], meas_sat); end
            tick();
            checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL width_popped w=%0d got=%0b exp=0", widths[i], meas_valid); end
            repeat (3) tick();
        end
        meas_ready = 1'b0;
    endtask

    task automatic test_saturation();
        do_clear();
        meas_ready = 1'b0;
        pulse(300);
        tick();
        checks++; if (meas_data !== 8'd255) begin errors++; $display("FAIL sat_data got=%0d exp=255", meas_data); end
        checks++; if (meas_sat !== 1'b1) begin errors++; $display("FAIL sat_flag got=%0b exp=1", meas_sat); end
        checks++; if (fill_level !== 3'd1) begin errors++; $display("FAIL sat_fill got=%0d exp=1", fill_level); end
        meas_ready = 1'b1;
        tick();
        meas_ready = 1'b0;
        pulse(2);
        tick();
        checks++; if (meas_data !== 8'd2) begin errors++; $display("FAIL after_sat_data got=%0d exp=2", meas_data); end
        checks++; if (meas_sat !== 1'b0) begin errors++; $display("FAIL after_sat_flag got=%0b exp=0", meas_sat); end
        checks++; if (fill_level !== 3'd1) begin errors++; $display("FAIL after_sat_fill got=%0d exp=1", fill_level); end
        do_clear();
    endtask

    task automatic test_overflow();
        meas_ready = 1'b0;
        for (int w = 2; w <= 7; w++) begin
            pulse(w);
            repeat (2) tick();
        end
        checks++; if (fill_level !== 3'd4) begin errors++; $display("FAIL ovf_fill got=%0d exp=4", fill_level); end
        checks++; if (drop_flag !== 1'b1) begin errors++; $display("FAIL ovf_drop got=%0b exp=1", drop_flag); end
        meas_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (meas_valid !== 1'b1 || meas_data !== 8'(2 + i)) begin errors++; $display("FAIL ovf_drain%0d got=%0b/%0d exp=1/%0d", i, meas_valid, meas_data, 2 + i); end
            tick();
        end
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%0b exp=0", meas_valid); end
        checks++; if (drop_flag !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", drop_flag); end
        meas_ready = 1'b0;
        do_clear();
        checks++; if (drop_flag !== 1'b0) begin errors++; $display("FAIL ovf_cleared got=%0b exp=0", drop_flag); end
    endtask

    task automatic test_full_pop();
        meas_ready = 1'b0;
        for (int w = 2; w <= 5; w++) begin
            pulse(w);
            repeat (2) tick();
        end
        checks++; if (fill_level !== 3'd4) begin errors++; $display("FAIL fp_fill_before got=%0d exp=4", fill_level); end
        pulse(6);
        meas_ready = 1'b1;
        tick();
        checks++; if (fill_level !== 3'd4) begin errors++; $display("FAIL fp_fill got=%0d exp=4", fill_level); end
        checks++; if (drop_flag !== 1'b0) begin errors++; $display("FAIL fp_drop got=%0b exp=0", drop_flag); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (meas_valid !== 1'b1 || meas_data !== 8'(3 + i)) begin errors++; $display("FAIL fp_drain%0d got=%0b/%0d exp=1/%0d", i, meas_valid, meas_data, 3 + i); end
            tick();
        end
        checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL fp_empty got=%0d exp=0", fill_level); end
        meas_ready = 1'b0;
        do_clear();
    endtask

    task automatic test_min_width();
        meas_ready = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            pulse(w);
            repeat (3) tick();
        end
        checks++; if (m3_fill !== 3'd1) begin errors++; $display("FAIL min_fill got=%0d exp=1", m3_fill); end
        checks++; if (m3_data !== 8'd3 || m3_sat !== 1'b0) begin errors++; $display("FAIL min_data got=%0d/%0b exp=3/0", m3_data, m3_sat); end
        checks++; if (m3_drop !== 1'b0 || m3_valid !== 1'b1) begin errors++; $display("FAIL min_flags got=drop%0b valid%0b exp=drop0 valid1", m3_drop, m3_valid); end
        checks++; if (fill_level !== 3'd3 || meas_data !== 8'd1) begin errors++; $display("FAIL min_ref got=%0d/%0d exp=3/1", fill_level, meas_data); end
        do_clear();
    endtask

    task automatic test_high_at_reset();
        reset = 1'b0;
        sig_in = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        repeat (10) tick();
        sig_in = 1'b0;
        repeat (3) tick();
        checks++; if (meas_valid !== 1'b0 || fill_level !== 3'd0) begin errors++; $display("FAIL rst_high got=%0b/%0d exp=0/0", meas_valid, fill_level); end
        checks++; if (m3_valid !== 1'b0) begin errors++; $display("FAIL rst_high_m3 got=%0b exp=0", m3_valid); end
    endtask

    task automatic test_clear_mid_pulse();
        meas_ready = 1'b0;
        pulse(2);
        repeat (2) tick();
        checks++; if (fill_level !== 3'd1) begin errors++; $display("FAIL clr_pre_fill got=%0d exp=1", fill_level); end
        sig_in = 1'b1;
        repeat (3) tick();
        do_clear();
        checks++; if (meas_valid !== 1'b0 || fill_level !== 3'd0) begin errors++; $display("FAIL clr_flush got=%0b/%0d exp=0/0", meas_valid, fill_level); end
        repeat (3) tick();
        sig_in = 1'b0;
        repeat (2) tick();
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL clr_no_entry got=%0b exp=0", meas_valid); end
        pulse(4);
        tick();
        checks++; if (meas_valid !== 1'b1 || meas_data !== 8'd4) begin errors++; $display("FAIL clr_next got=%0b/%0d exp=1/4", meas_valid, meas_data); end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_widths();
        test_saturation();
        test_overflow();
        test_full_pop();
        test_min_width();
        test_high_at_reset();
        test_clear_mid_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
